mux_func_scanner: RTL and testbench

- Sequencer that owns one shared `mux8_to_1` instance configured as a 4-input function generator.
- Select bus = {a,b,c}; each of the 8 data inputs is programmed as 0, 1, d or ~d.
- On request, walks all 16 input combinations {a,b,c,d}, captures the mux output into a 16-bit truth table and compares it against an expected table.
- Used as the self-check/characterisation engine for mux-based function labs; replaces hand-wired constant patterns with a runtime config word.

---
 rtl/mux_func_scanner_pkg.sv | 32 +++
 rtl/mux8_to_1.sv | 10 +
 rtl/mux_cfg_decoder.sv | 18 +
 rtl/mux_func_scanner.sv | 119 +++++++++++
 tb/tb_mux_func_scanner.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_func_scanner_pkg.sv
// Shared types and constants for the mux function scanner: FSM states,
// 2-bit data-input codes and the code-to-level decode used by the config decoder.
package mux_scan_pkg;

  localparam int N_SEL = 3;
  localparam int N_IN  = 2 ** N_SEL;
  localparam int TT_W  = 2 ** (N_SEL + 1);
  localparam int CFG_W = 2 * N_IN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] ONE  = 2'b01;
  localparam logic [1:0] D    = 2'b10;
  localparam logic [1:0] ND   = 2'b11;

  function automatic logic decode_code(input logic [1:0] code, input logic d);
    logic lvl;
    case (code)
      ZERO:    lvl = 1'b0;
      ONE:     lvl = 1'b1;
      D:       lvl = d;
      default: lvl = ~d;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/mux8_to_1.sv
// Plain 8:1 multiplexer; the shared datapath element of the function generator.
module mux8_to_1 (
  input  logic [7:0] data,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = data[sel];

endmodule

// File: rtl/mux_cfg_decoder.sv
// Expands the latched 16-bit config word into the mux data bus for the
// current value of d; each 2-bit field selects 0, 1, d or ~d.
module mux_cfg_decoder
  import mux_scan_pkg::*;
(
  input  logic [CFG_W-1:0] cfg_q,
  input  logic             d,
  output logic [N_IN-1:0]  data
);

  always_comb begin
    data = '0;
    for (int k = 0; k < N_IN; k++) begin
      data[k] = decode_code(cfg_q[2*k +: 2], d);
    end
  end

endmodule

// File: rtl/mux_func_scanner.sv
// Walks all 16 {a,b,c,d} combinations through one mux8_to_1 programmed from a
// config word, captures the truth table and compares it with a reference.
module mux_func_scanner
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CFG_W-1:0] cfg,
  input  logic [TT_W-1:0]  expected,
  output logic             busy,
  output logic             done,
  output logic [TT_W-1:0]  result,
  output logic             match,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o
);

  localparam logic [N_SEL:0] IDX_LAST = '1;

  state_t            state;
  state_t            state_next;
  logic [N_SEL:0]    idx;
  logic [CFG_W-1:0]  cfg_q;
  logic [TT_W-1:0]   exp_q;
  logic [TT_W-1:0]   tt_next;
  logic [N_IN-1:0]   mux_data;
  logic              y;
  logic              last;
  logic              accept;

  assign last   = (idx == IDX_LAST);
  assign accept = start && !abort;

  mux_cfg_decoder u_decoder (
    .cfg_q (cfg_q),
    .d     (idx[0]),
    .data  (mux_data)
  );

  mux8_to_1 u_mux (
    .data (mux_data),
    .sel  (idx[N_SEL:1]),
    .y    (y)
  );

  // Truth table with the current mux output merged in; also feeds the final compare
  always_comb begin
    tt_next      = result;
    tt_next[idx] = y;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SCAN;
      SCAN: begin
        if (abort)     state_next = IDLE;
        else if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SCAN);
    {a_o, b_o, c_o, d_o} = (state == SCAN) ? idx : '0;
  end

  // Datapath: config/reference latch, capture counter, result and match
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= '0;
      cfg_q  <= '0;
      exp_q  <= '0;
      result <= '0;
      match  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cfg_q  <= cfg;
            exp_q  <= expected;
            result <= '0;
            match  <= 1'b0;
            idx    <= '0;
          end
        end
        SCAN: begin
          if (abort) begin
            idx   <= '0;
            match <= 1'b0;
          end else begin
            result <= tt_next;
            idx    <= idx + 1'b1;
            if (last) match <= (tt_next == exp_q);
          end
        end
        DONE: begin
          if (abort) match <= 1'b0;
          else       done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_func_scanner.sv
// Directed bench for mux_func_scanner: reset, lab function, constant/d patterns,
// input latching, ignored starts and abort.
module tb_mux_func_scanner;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg;
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        match;
  logic        a_o, b_o, c_o, d_o;

  int n_checks = 0;
  int n_pass   = 0;

  mux_func_scanner dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .abort    (abort),
    .cfg      (cfg),
    .expected (expected),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .match    (match),
    .a_o      (a_o),
    .b_o      (b_o),
    .c_o      (c_o),
    .d_o      (d_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a start and counts edges until done is seen (bounded at 40)
  task automatic run_scan(input logic [15:0] c, input logic [15:0] e, output int lat);
    cfg      = c;
    expected = e;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; cfg = 16'h0; expected = 16'h0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_checks++; if (result !== 16'h0000) $display("FAIL rst_result got %h want 0000", result); else n_pass++;
    n_checks++; if (match !== 1'b0) $display("FAIL rst_match got %b want 0", match); else n_pass++;
    n_checks++; if ({a_o,b_o,c_o,d_o} !== 4'h0) $display("FAIL rst_stim got %h want 0", {a_o,b_o,c_o,d_o}); else n_pass++;
    reset_n = 1'b1;
    tick();
    // Start a scan and reset asynchronously at idx=7
    cfg = 16'h87B9; expected = 16'h8D9B; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    n_checks++; if ({a_o,b_o,c_o,d_o} !== 4'h7) $display("FAIL mid_idx got %h want 7", {a_o,b_o,c_o,d_o}); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (result !== 16'h0000) $display("FAIL midrst_result got %h want 0000", result); else n_pass++;
    n_checks++; if ({a_o,b_o,c_o,d_o} !== 4'h0) $display("FAIL midrst_stim got %h want 0", {a_o,b_o,c_o,d_o}); else n_pass++;
    tick();
    reset_n = 1'b1;
    begin
      int pulses = 0;
      for (int k = 0; k < 25; k++) begin
        tick();
        if (done) pulses++;
      end
      n_checks++; if (pulses !== 0) $display("FAIL midrst_done_pulses got %0d want 0", pulses); else n_pass++;
    end
  endtask

  task automatic test_lab();
    int lat;
    run_scan(16'h87B9, 16'h8D9B, lat);
    n_checks++; if (lat !== 17) $display("FAIL lab_latency got %0d want 17", lat); else n_pass++;
    n_checks++; if (result !== 16'h8D9B) $display("FAIL lab_result got %h want 8d9b", result); else n_pass++;
    n_checks++; if (match !== 1'b1) $display("FAIL lab_match got %b want 1", match); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL lab_done_width got %b want 0", done); else n_pass++;
    n_checks++; if (result !== 16'h8D9B) $display("FAIL lab_hold got %h want 8d9b", result); else n_pass++;
  endtask

  task automatic test_patterns();
    logic [15:0] cfgs [4] = '{16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF};
    logic [15:0] tts  [4] = '{16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555};
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_scan(cfgs[i], tts[i], lat);
      n_checks++; if (lat !== 17) $display("FAIL pat%0d_latency got %0d want 17", i, lat); else n_pass++;
      n_checks++; if (result !== tts[i]) $display("FAIL pat%0d_result got %h want %h", i, result, tts[i]); else n_pass++;
      n_checks++; if (match !== 1'b1) $display("FAIL pat%0d_match got %b want 1", i, match); else n_pass++;
      tick();
    end
  endtask

  task automatic test_latch();
    int lat;
    cfg = 16'h5555; expected = 16'hFFFE; start = 1'b1;
    tick();
    start = 1'b0;
    cfg = 16'h0000; expected = 16'h0000;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (lat == 3) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL latch_busy got %b want 1", busy); else n_pass++;
      end
      if (done) break;
    end
    n_checks++; if (lat !== 17) $display("FAIL latch_latency got %0d want 17", lat); else n_pass++;
    n_checks++; if (result !== 16'hFFFF) $display("FAIL latch_result got %h want ffff", result); else n_pass++;
    n_checks++; if (match !== 1'b0) $display("FAIL latch_match got %b want 0", match); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int lat;
    cfg = 16'h87B9; expected = 16'h8D9B; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) pulses++;
      if (k == 17) begin
        n_checks++; if (done !== 1'b1) $display("FAIL b2b_done_at17 got %b want 1", done); else n_pass++;
      end
      if (k == 18) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_no_restart got %b want 0", busy); else n_pass++;
      end
      start = (k == 5) || (k == 16);
    end
    start = 1'b0;
    n_checks++; if (pulses !== 1) $display("FAIL b2b_done_pulses got %0d want 1", pulses); else n_pass++;
    n_checks++; if (result !== 16'h8D9B) $display("FAIL b2b_result got %h want 8d9b", result); else n_pass++;
    run_scan(16'hAAAA, 16'hAAAA, lat);
    n_checks++; if (lat !== 17) $display("FAIL b2b_next_latency got %0d want 17", lat); else n_pass++;
    n_checks++; if (result !== 16'hAAAA) $display("FAIL b2b_next_result got %h want aaaa", result); else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    int pulses = 0;
    int busy_seen = 0;
    int lat;
    run_scan(16'h87B9, 16'h8D9B, lat);
    n_checks++; if (match !== 1'b1) $display("FAIL abort_pre_match got %b want 1", match); else n_pass++;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    n_checks++; if ({a_o,b_o,c_o,d_o} !== 4'hF) $display("FAIL abort_idx got %h want f", {a_o,b_o,c_o,d_o}); else n_pass++;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (match !== 1'b0) $display("FAIL abort_match got %b want 0", match); else n_pass++;
    n_checks++; if ({a_o,b_o,c_o,d_o} !== 4'h0) $display("FAIL abort_stim got %h want 0", {a_o,b_o,c_o,d_o}); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else n_pass++;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) pulses++;
      if (busy) busy_seen++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL abort_done_pulses got %0d want 0", pulses); else n_pass++;
    n_checks++; if (busy_seen !== 0) $display("FAIL abort_idle_busy got %0d want 0", busy_seen); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lab();
    test_patterns();
    test_latch();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
